// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle RV32I control FSM and the datapath muxes it steers.
// Opcodes, state codes and every select/op-type value live here so both sides agree.
package multicycle_control_pkg;

  localparam logic [6:0] OPCODE_LOAD     = 7'b000_0011;
  localparam logic [6:0] OPCODE_MISC_MEM = 7'b000_1111;
  localparam logic [6:0] OPCODE_OP_IMM   = 7'b001_0011;
  localparam logic [6:0] OPCODE_AUIPC    = 7'b001_0111;
  localparam logic [6:0] OPCODE_STORE    = 7'b010_0011;
  localparam logic [6:0] OPCODE_OP       = 7'b011_0011;
  localparam logic [6:0] OPCODE_LUI      = 7'b011_0111;
  localparam logic [6:0] OPCODE_BRANCH   = 7'b110_0011;
  localparam logic [6:0] OPCODE_JALR     = 7'b110_0111;
  localparam logic [6:0] OPCODE_JAL      = 7'b110_1111;
  localparam logic [6:0] OPCODE_SYSTEM   = 7'b111_0011;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_e;

  localparam logic [1:0] NPC_PLUS4  = 2'd0;
  localparam logic [1:0] NPC_IMM    = 2'd1;
  localparam logic [1:0] NPC_ALU    = 2'd2;
  localparam logic       ADDR_PC    = 1'b0;
  localparam logic       ADDR_ALU   = 1'b1;
  localparam logic [1:0] SRC_A_RS1  = 2'd0;
  localparam logic [1:0] SRC_A_PC   = 2'd1;
  localparam logic [1:0] SRC_A_ZERO = 2'd2;
  localparam logic [1:0] SRC_B_RS2  = 2'd0;
  localparam logic [1:0] SRC_B_IMM  = 2'd1;
  localparam logic [1:0] SRC_B_FOUR = 2'd2;
  localparam logic [1:0] ALU_ADD    = 2'd0;
  localparam logic [1:0] ALU_OP     = 2'd1;
  localparam logic [1:0] ALU_OP_IMM = 2'd2;
  localparam logic [1:0] ALU_BRANCH = 2'd3;
  localparam logic [1:0] WB_ALU     = 2'd0;
  localparam logic [1:0] WB_LOAD    = 2'd1;
  localparam logic [1:0] WB_PC4     = 2'd2;

  typedef struct packed {
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] op;
  } alu_ctrl_t;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] next_pc_sel;
    logic       inst_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_addr_sel;
    alu_ctrl_t  alu;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       illegal;
  } ctrl_t;

  // LOAD_FP/STORE_FP and anything else outside RV32I fall through to illegal.
  function automatic logic is_legal(input logic [6:0] opcode);
    case (opcode)
      OPCODE_LOAD, OPCODE_MISC_MEM, OPCODE_OP_IMM, OPCODE_AUIPC, OPCODE_STORE,
      OPCODE_OP, OPCODE_LUI, OPCODE_BRANCH, OPCODE_JALR, OPCODE_JAL,
      OPCODE_SYSTEM: is_legal = 1'b1;
      default:       is_legal = 1'b0;
    endcase
  endfunction

  function automatic alu_ctrl_t alu_ctrl(input logic [6:0] opcode);
    case (opcode)
      OPCODE_LOAD, OPCODE_STORE, OPCODE_JALR: alu_ctrl = '{SRC_A_RS1, SRC_B_IMM, ALU_ADD};
      OPCODE_OP:     alu_ctrl = '{SRC_A_RS1, SRC_B_RS2, ALU_OP};
      OPCODE_OP_IMM: alu_ctrl = '{SRC_A_RS1, SRC_B_IMM, ALU_OP_IMM};
      OPCODE_LUI:    alu_ctrl = '{SRC_A_ZERO, SRC_B_IMM, ALU_ADD};
      OPCODE_AUIPC:  alu_ctrl = '{SRC_A_PC, SRC_B_IMM, ALU_ADD};
      OPCODE_BRANCH: alu_ctrl = '{SRC_A_RS1, SRC_B_RS2, ALU_BRANCH};
      default:       alu_ctrl = '{SRC_A_RS1, SRC_B_RS2, ALU_ADD};
    endcase
  endfunction

endpackage

// File: rtl/control_output_decoder.sv
// Purely combinational strobe/select decode from FSM state, IR opcode and the handshakes.
// ALU selects are held through MEM and WRITEBACK so the ALU result stays valid for address and writeback.
module control_output_decoder
  import multicycle_control_pkg::*;
(
  input  state_e     state,
  input  logic [6:0] opcode,
  input  logic       take_branch,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read     = 1'b1;
        ctrl.mem_addr_sel = ADDR_PC;
        ctrl.inst_write   = mem_ready;
      end
      S_EXECUTE: begin
        ctrl.alu = alu_ctrl(opcode);
        case (opcode)
          OPCODE_BRANCH: begin
            ctrl.pc_write    = 1'b1;
            ctrl.next_pc_sel = take_branch ? NPC_IMM : NPC_PLUS4;
          end
          OPCODE_LOAD, OPCODE_STORE, OPCODE_OP, OPCODE_OP_IMM, OPCODE_LUI,
          OPCODE_AUIPC, OPCODE_JAL, OPCODE_JALR: ;
          default: begin
            ctrl.pc_write    = 1'b1;
            ctrl.next_pc_sel = NPC_PLUS4;
          end
        endcase
      end
      S_MEM: begin
        ctrl.alu          = alu_ctrl(opcode);
        ctrl.mem_addr_sel = ADDR_ALU;
        if (opcode == OPCODE_LOAD) begin
          ctrl.mem_read = 1'b1;
        end else begin
          ctrl.mem_write   = 1'b1;
          ctrl.pc_write    = mem_ready;
          ctrl.next_pc_sel = NPC_PLUS4;
        end
      end
      S_WRITEBACK: begin
        ctrl.alu       = alu_ctrl(opcode);
        ctrl.reg_write = 1'b1;
        ctrl.pc_write  = 1'b1;
        case (opcode)
          OPCODE_LOAD: ctrl.wb_sel = WB_LOAD;
          OPCODE_JAL: begin
            ctrl.wb_sel      = WB_PC4;
            ctrl.next_pc_sel = NPC_IMM;
          end
          OPCODE_JALR: begin
            ctrl.wb_sel      = WB_PC4;
            ctrl.next_pc_sel = NPC_ALU;
          end
          default: ctrl.wb_sel = WB_ALU;
        endcase
      end
      S_HALT:  ctrl.illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Sequencing FSM for the multicycle RV32I core: state register, next-state logic and reset gating.
// PC is only written when an instruction retires, so PC holds the current instruction address.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] inst_opcode,
  input  logic       mem_ready,
  input  logic       take_branch,
  output logic       pc_write_enable,
  output logic [1:0] next_pc_select,
  output logic       inst_write_enable,
  output logic       mem_read_enable,
  output logic       mem_write_enable,
  output logic       mem_addr_select,
  output logic [1:0] alu_src_a_select,
  output logic [1:0] alu_src_b_select,
  output logic [1:0] alu_op_type,
  output logic       regfile_write_enable,
  output logic [1:0] reg_writeback_select,
  output logic       illegal_inst,
  output logic [2:0] state_debug
);

  state_e state_q, state_d;
  ctrl_t  dec_ctrl, out_ctrl;

  always_ff @(posedge clock or posedge reset) begin
    // NOTE: non-blocking so every flop samples pre-edge values regardless of block ordering.
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: state_d = (ILLEGAL_TRAP && !is_legal(inst_opcode)) ? S_HALT : S_EXECUTE;
      S_EXECUTE: begin
        case (inst_opcode)
          OPCODE_LOAD, OPCODE_STORE: state_d = S_MEM;
          OPCODE_OP, OPCODE_OP_IMM, OPCODE_LUI, OPCODE_AUIPC, OPCODE_JAL,
          OPCODE_JALR: state_d = S_WRITEBACK;
          default:     state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (mem_ready) state_d = (inst_opcode == OPCODE_LOAD) ? S_WRITEBACK : S_FETCH;
      end
      S_WRITEBACK: state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_FETCH;
    endcase
  end

  control_output_decoder u_decoder (
    .state       (state_q),
    .opcode      (inst_opcode),
    .take_branch (take_branch),
    .mem_ready   (mem_ready),
    .ctrl        (dec_ctrl)
  );

  // Reset gates every strobe combinationally so an abort drops them before the next edge.
  assign out_ctrl = reset ? '0 : dec_ctrl;

  assign pc_write_enable      = out_ctrl.pc_write;
  assign next_pc_select       = out_ctrl.next_pc_sel;
  assign inst_write_enable    = out_ctrl.inst_write;
  assign mem_read_enable      = out_ctrl.mem_read;
  assign mem_write_enable     = out_ctrl.mem_write;
  assign mem_addr_select      = out_ctrl.mem_addr_sel;
  assign alu_src_a_select     = out_ctrl.alu.src_a;
  assign alu_src_b_select     = out_ctrl.alu.src_b;
  assign alu_op_type          = out_ctrl.alu.op;
  assign regfile_write_enable = out_ctrl.reg_write;
  assign reg_writeback_select = out_ctrl.wb_sel;
  assign illegal_inst         = out_ctrl.illegal;
  assign state_debug          = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized instruction-level bench: each instruction expands into its expected phase sequence,
// and every cycle's outputs are compared with the values those phases call for.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  typedef enum {PF, PD, PE, PM, PW, PH, PR} ph_t;

  typedef struct packed {
    logic pc_we; logic [1:0] npc; logic inst_we; logic mrd; logic mwr; logic asel;
    logic [1:0] a; logic [1:0] b; logic [1:0] op; logic rwe; logic [1:0] wb; logic ill;
    logic [2:0] st;
  } ctl_t;

  logic clock = 1'b0;
  logic reset_a, reset_b, use_nop;
  logic [6:0] inst_opcode;
  logic mem_ready, take_branch;

  logic a_pc_we, a_inst_we, a_mrd, a_mwr, a_asel, a_rwe, a_ill;
  logic [1:0] a_npc, a_a, a_b, a_op, a_wb;
  logic [2:0] a_st;
  logic b_pc_we, b_inst_we, b_mrd, b_mwr, b_asel, b_rwe, b_ill;
  logic [1:0] b_npc, b_a, b_b, b_op, b_wb;
  logic [2:0] b_st;
  ctl_t obs_a, obs_b, obs;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  multicycle_control #(.ILLEGAL_TRAP(1'b1)) dut_trap (
    .clock(clock), .reset(reset_a), .inst_opcode(inst_opcode), .mem_ready(mem_ready),
    .take_branch(take_branch), .pc_write_enable(a_pc_we), .next_pc_select(a_npc),
    .inst_write_enable(a_inst_we), .mem_read_enable(a_mrd), .mem_write_enable(a_mwr),
    .mem_addr_select(a_asel), .alu_src_a_select(a_a), .alu_src_b_select(a_b),
    .alu_op_type(a_op), .regfile_write_enable(a_rwe), .reg_writeback_select(a_wb),
    .illegal_inst(a_ill), .state_debug(a_st)
  );

  multicycle_control #(.ILLEGAL_TRAP(1'b0)) dut_nop (
    .clock(clock), .reset(reset_b), .inst_opcode(inst_opcode), .mem_ready(mem_ready),
    .take_branch(take_branch), .pc_write_enable(b_pc_we), .next_pc_select(b_npc),
    .inst_write_enable(b_inst_we), .mem_read_enable(b_mrd), .mem_write_enable(b_mwr),
    .mem_addr_select(b_asel), .alu_src_a_select(b_a), .alu_src_b_select(b_b),
    .alu_op_type(b_op), .regfile_write_enable(b_rwe), .reg_writeback_select(b_wb),
    .illegal_inst(b_ill), .state_debug(b_st)
  );

  assign obs_a = {a_pc_we, a_npc, a_inst_we, a_mrd, a_mwr, a_asel, a_a, a_b, a_op,
                  a_rwe, a_wb, a_ill, a_st};
  assign obs_b = {b_pc_we, b_npc, b_inst_we, b_mrd, b_mwr, b_asel, b_a, b_b, b_op,
                  b_rwe, b_wb, b_ill, b_st};
  assign obs = use_nop ? obs_b : obs_a;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit legal_op(input logic [6:0] op);
    case (op)
      7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Phases in which the ALU selects carry a defined meaning for this opcode.
  function automatic bit alu_defined(input ph_t ph, input logic [6:0] op);
    if (ph == PM || ph == PR) return 1'b1;
    if (ph == PW) return op == 7'h67;
    if (ph == PE) begin
      case (op)
        7'h03, 7'h23, 7'h33, 7'h13, 7'h37, 7'h17, 7'h67, 7'h63: return 1'b1;
        default: return 1'b0;
      endcase
    end
    return 1'b0;
  endfunction

  function automatic ctl_t model(input ph_t ph, input logic [6:0] op, input logic tb,
                                 input logic mr);
    ctl_t e;
    e = '0;
    case (ph)
      PF: begin e.st = S_FETCH; e.mrd = 1'b1; e.inst_we = mr; end
      PD: e.st = S_DECODE;
      PE: begin
        e.st = S_EXECUTE;
        case (op)
          7'h03, 7'h23, 7'h67: e.b = 2'd1;
          7'h33: e.op = 2'd1;
          7'h13: begin e.b = 2'd1; e.op = 2'd2; end
          7'h37: begin e.a = 2'd2; e.b = 2'd1; end
          7'h17: begin e.a = 2'd1; e.b = 2'd1; end
          7'h6F: ;
          7'h63: begin e.op = 2'd3; e.pc_we = 1'b1; e.npc = tb ? 2'd1 : 2'd0; end
          default: e.pc_we = 1'b1;
        endcase
      end
      PM: begin
        e.st = S_MEM; e.asel = 1'b1; e.b = 2'd1;
        if (op == 7'h03) e.mrd = 1'b1;
        else begin e.mwr = 1'b1; e.pc_we = mr; end
      end
      PW: begin
        e.st = S_WRITEBACK; e.rwe = 1'b1; e.pc_we = 1'b1;
        if (op == 7'h03) e.wb = 2'd1;
        if (op == 7'h6F) begin e.wb = 2'd2; e.npc = 2'd1; end
        if (op == 7'h67) begin e.wb = 2'd2; e.npc = 2'd2; e.b = 2'd1; end
      end
      PH: begin e.st = S_HALT; e.ill = 1'b1; end
      default: e.st = S_FETCH;
    endcase
    return e;
  endfunction

  task automatic cmp(input ph_t ph, input logic [6:0] op, input logic tb, input logic mr,
                     input string ctx);
    ctl_t e, g;
    bit all;
    e = model(ph, op, tb, mr);
    g = obs;
    all = (ph == PR);
    check({ctx, " state"}, 32'(g.st), 32'(e.st));
    check({ctx, " pc_we"}, 32'(g.pc_we), 32'(e.pc_we));
    check({ctx, " inst_we"}, 32'(g.inst_we), 32'(e.inst_we));
    check({ctx, " mem_rd"}, 32'(g.mrd), 32'(e.mrd));
    check({ctx, " mem_wr"}, 32'(g.mwr), 32'(e.mwr));
    check({ctx, " rf_we"}, 32'(g.rwe), 32'(e.rwe));
    check({ctx, " illegal"}, 32'(g.ill), 32'(e.ill));
    if (all || e.pc_we) check({ctx, " npc_sel"}, 32'(g.npc), 32'(e.npc));
    if (all || e.rwe) check({ctx, " wb_sel"}, 32'(g.wb), 32'(e.wb));
    if (all || ph == PF || ph == PM) check({ctx, " addr_sel"}, 32'(g.asel), 32'(e.asel));
    if (alu_defined(ph, op)) begin
      check({ctx, " alu_a"}, 32'(g.a), 32'(e.a));
      check({ctx, " alu_b"}, 32'(g.b), 32'(e.b));
      check({ctx, " alu_op"}, 32'(g.op), 32'(e.op));
    end
  endtask

  task automatic set_reset(input logic v);
    if (use_nop) reset_b = v;
    else         reset_a = v;
  endtask

  // Asserts reset now, holds it across one edge, releases with memory idle.
  task automatic apply_reset(input string ctx);
    set_reset(1'b1);
    #1 cmp(PR, 7'h00, 1'b0, 1'b0, {ctx, " in-reset"});
    @(negedge clock);
    mem_ready = 1'b0;
    #1 cmp(PR, 7'h00, 1'b0, 1'b0, {ctx, " held-reset"});
    set_reset(1'b0);
    #1 cmp(PF, inst_opcode, take_branch, 1'b0, {ctx, " post-reset"});
  endtask

  task automatic run_instr(input logic [6:0] op, input int nf, input int nm, input int nh,
                           input int tb_force, input int abort_at, input string name);
    ph_t q[$];
    int fcnt, mcnt;
    bit halted, aborted;
    fcnt = 0; mcnt = 0; halted = 1'b0; aborted = 1'b0;
    for (int i = 0; i <= nf; i++) q.push_back(PF);
    q.push_back(PD);
    if (!legal_op(op) && !use_nop) begin
      for (int i = 0; i < nh; i++) q.push_back(PH);
    end else begin
      q.push_back(PE);
      if (op == 7'h03 || op == 7'h23)
        for (int i = 0; i <= nm; i++) q.push_back(PM);
      if (op == 7'h03 || op == 7'h33 || op == 7'h13 || op == 7'h37 || op == 7'h17 ||
          op == 7'h6F || op == 7'h67) q.push_back(PW);
    end
    for (int k = 0; k < q.size() && !aborted; k++) begin
      @(negedge clock);
      case (q[k])
        PF: begin mem_ready = (fcnt == nf); fcnt++; end
        PM: begin mem_ready = (mcnt == nm); mcnt++; end
        default: mem_ready = 1'($urandom);
      endcase
      inst_opcode = (q[k] == PF) ? 7'($urandom) : op;
      take_branch = (tb_force < 0) ? 1'($urandom) : tb_force[0];
      #1 cmp(q[k], op, take_branch, mem_ready, $sformatf("%s c%0d", name, k));
      if (q[k] == PH) halted = 1'b1;
      if (k == abort_at) begin
        apply_reset({name, " abort"});
        aborted = 1'b1;
      end
    end
    if (halted && !aborted) begin
      @(negedge clock);
      apply_reset({name, " halt-exit"});
    end
  endtask

  function automatic logic [6:0] pick_op();
    logic [6:0] ops [14] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37,
                             7'h63, 7'h67, 7'h6F, 7'h73, 7'h07, 7'h27, 7'h7F};
    if ($urandom_range(0, 7) == 0) return 7'($urandom);
    return ops[$urandom_range(0, 13)];
  endfunction

  task automatic random_run(input int n, input string name);
    for (int i = 0; i < n; i++)
      run_instr(pick_op(), $urandom_range(0, 2), $urandom_range(0, 2), 3, -1, -1,
                $sformatf("%s%0d", name, i));
  endtask

  initial begin
    logic [31:0] w;
    use_nop = 1'b0; reset_a = 1'b1; reset_b = 1'b1;
    mem_ready = 1'b0; take_branch = 1'b0; inst_opcode = 7'h00;
    #2 cmp(PR, 7'h00, 1'b0, 1'b0, "trap reset");
    use_nop = 1'b1;
    #1 cmp(PR, 7'h00, 1'b0, 1'b0, "nop reset");
    use_nop = 1'b0;
    @(negedge clock);
    reset_a = 1'b0;
    #1 cmp(PF, inst_opcode, take_branch, 1'b0, "trap release");

    w = 32'h00500093; run_instr(w[6:0], 0, 0, 0, -1, -1, "addi");
    w = 32'h0000A103; run_instr(w[6:0], 0, 2, 0, -1, -1, "lw");
    w = 32'h00000463; run_instr(w[6:0], 0, 0, 0, 1, -1, "beq_t");
    run_instr(w[6:0], 1, 0, 0, 0, -1, "beq_nt");
    w = 32'h000080E7; run_instr(w[6:0], 0, 0, 0, -1, -1, "jalr");
    run_instr(7'h6F, 0, 0, 0, -1, -1, "jal");
    run_instr(7'h7F, 0, 0, 20, -1, -1, "illegal_trap");
    w = 32'h0020A023; run_instr(w[6:0], 0, 2, 0, -1, 4, "sw_abort");
    run_instr(w[6:0], 0, 0, 0, -1, -1, "sw");
    random_run(150, "rt");

    @(negedge clock);
    reset_a = 1'b1;
    use_nop = 1'b1;
    mem_ready = 1'b0;
    reset_b = 1'b0;
    #1 cmp(PF, inst_opcode, take_branch, 1'b0, "nop release");
    run_instr(7'h7F, 0, 0, 0, -1, -1, "illegal_nop");
    run_instr(7'h07, 1, 0, 0, -1, -1, "load_fp_nop");
    random_run(150, "rn");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
